// File: rtl/rand_share_arbiter.sv
// Round-robin sharer of one 64-bit random source across NREQ units; each source word is handed out once.
// Latency: grant in IDLE at T -> ack at T+2 (scalar) / T+4 (vector); requesters wait by holding req until ack.
module rand_share_arbiter #(
  parameter int NREQ   = 4,
  parameter int IDW    = 2,
  parameter int WARMUP = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [63:0]           rand_in,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       req_vec,
  output logic [NREQ-1:0]       ack,
  output logic [2:0][63:0]      rand_out,
  output logic [IDW-1:0]        out_id,
  output logic                  busy
);

  localparam int WW = $clog2(WARMUP + 1);

  typedef enum logic [1:0] {
    WARM = 2'd0,
    IDLE = 2'd1,
    COLL = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [WW-1:0]   warm_cnt;
  logic [1:0]      cnt;
  logic [IDW-1:0]  ptr;
  logic            mode_vec;
  logic            coll_last;
  logic            grant_vld;
  logic [IDW-1:0]  grant_id;

  // Wrapping add kept explicit so non-power-of-two NREQ never lands on a missing requester.
  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return s[IDW-1:0];
  endfunction

  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!grant_vld && req[rr_idx(ptr, i)]) begin
        grant_vld = 1'b1;
        grant_id  = rr_idx(ptr, i);
      end
    end
  end

  assign coll_last = mode_vec ? (cnt == 2'd2) : (cnt == 2'd0);

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    case (state)
      WARM: if (warm_cnt == WW'(WARMUP - 1)) state_nxt = IDLE;
      IDLE: begin
        busy = 1'b0;
        if (grant_vld) state_nxt = COLL;
      end
      COLL: if (coll_last) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = WARM;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= WARM;
    else       state <= state_nxt;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      warm_cnt <= '0;
      cnt      <= '0;
      ptr      <= IDW'(NREQ - 1);
      mode_vec <= 1'b0;
      out_id   <= '0;
      rand_out <= '0;
      ack      <= '0;
    end else begin
      ack <= '0;
      case (state)
        WARM: warm_cnt <= warm_cnt + 1'b1;
        IDLE: begin
          if (grant_vld) begin
            out_id   <= grant_id;
            ptr      <= grant_id;
            mode_vec <= req_vec[grant_id];
            cnt      <= '0;
          end
        end
        COLL: begin
          case (cnt)
            2'd0: rand_out[0] <= rand_in;
            2'd1: rand_out[1] <= rand_in;
            2'd2: rand_out[2] <= rand_in;
            default: ;
          endcase
          // A scalar must not expose stale y/z words from an earlier vector.
          if (!mode_vec) begin
            rand_out[1] <= '0;
            rand_out[2] <= '0;
          end
          cnt <= cnt + 2'd1;
          if (coll_last) ack <= NREQ'(1) << out_id;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rand_share_arbiter.sv
// Bench for rand_share_arbiter: directed scenarios plus random traffic against a timeline model.
module tb_rand_share_arbiter;
  localparam int NREQ   = 4;
  localparam int IDW    = 2;
  localparam int WARMUP = 16;

  logic                  Clk = 1'b0;
  logic                  Reset = 1'b1;
  logic [63:0]           rand_in = '0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ-1:0]       req_vec = '0;
  logic [NREQ-1:0]       ack;
  logic [2:0][63:0]      rand_out;
  logic [IDW-1:0]        out_id;
  logic                  busy;

  rand_share_arbiter #(.NREQ(NREQ), .IDW(IDW), .WARMUP(WARMUP)) dut (
    .Clk(Clk), .Reset(Reset), .rand_in(rand_in), .req(req), .req_vec(req_vec),
    .ack(ack), .rand_out(rand_out), .out_id(out_id), .busy(busy)
  );

  always #5 Clk = ~Clk;

  int     checks = 0;
  int     failures = 0;
  longint cyc = 0;

  // Reference model: transactions as points on a cycle timeline.
  bit     chk_en = 0;
  longint ready_at = 0, free_at = 0, reset_cyc = -10;
  bit     txn_vld = 0;
  int     txn_id = 0;
  bit     txn_vec = 0;
  longint grant_cyc = 0, ack_cyc = 0;
  int     m_ptr = NREQ - 1;
  int     grants = 0;
  int     hold_pct = 0;
  bit     alt_mode = 0;
  int     alt_prev = -1;
  logic [NREQ-1:0] exp_ack_now;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_eval();
    int j;
    if (Reset) begin
      chk_en    = 1;
      reset_cyc = cyc;
      ready_at  = cyc + 1 + WARMUP;
      free_at   = 0;
      txn_vld   = 0;
      m_ptr     = NREQ - 1;
    end else if (chk_en && cyc >= ready_at && cyc >= free_at && req != 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        j = (m_ptr + k) % NREQ;
        if (req[j]) begin
          m_ptr     = j;
          txn_id    = j;
          txn_vec   = req_vec[j];
          txn_vld   = 1;
          grant_cyc = cyc;
          ack_cyc   = cyc + (txn_vec ? 4 : 2);
          free_at   = ack_cyc + 1;
          break;
        end
      end
    end
  endtask

  task automatic tick();
    longint w1, w2;
    model_eval();
    @(posedge Clk);
    #1;
    cyc++;
    rand_in = 64'(cyc);
    exp_ack_now = '0;
    if (!chk_en) return;
    if (txn_vld && cyc == ack_cyc) exp_ack_now[txn_id] = 1'b1;
    check_val("ack", 64'(ack), 64'(exp_ack_now));
    check_val("busy", 64'(busy), 64'(!(cyc >= ready_at && cyc >= free_at)));
    if (cyc == reset_cyc + 1) begin
      check_val("rst_rand0", rand_out[0], 64'd0);
      check_val("rst_rand1", rand_out[1], 64'd0);
      check_val("rst_rand2", rand_out[2], 64'd0);
      check_val("rst_id", 64'(out_id), 64'd0);
    end
    if (exp_ack_now != 0) begin
      w1 = txn_vec ? grant_cyc + 2 : 0;
      w2 = txn_vec ? grant_cyc + 3 : 0;
      check_val("rand_x", rand_out[0], 64'(grant_cyc + 1));
      check_val("rand_y", rand_out[1], 64'(w1));
      check_val("rand_z", rand_out[2], 64'(w2));
      check_val("out_id", 64'(out_id), 64'(txn_id));
      if (alt_mode) begin
        if (alt_prev >= 0) check_val("alternate", 64'(out_id), 64'((alt_prev == 1) ? 3 : 1));
        alt_prev = txn_id;
      end
      grants++;
      txn_vld = 0;
      if (int'($urandom_range(99)) >= hold_pct) req[txn_id] = 1'b0;
    end
  endtask

  initial begin
    int g0;
    // 1: single scalar requester straight out of reset
    Reset = 1; tick(); tick();
    Reset = 0; req = 4'b0001; req_vec = 4'b0000;
    repeat (WARMUP + 6) tick();
    check_val("t1_grants", 64'(grants), 64'd1);

    // 2: all four scalar, fresh pointer -> order 0,1,2,3
    Reset = 1; tick();
    Reset = 0; req = 4'b1111; req_vec = 4'b0000;
    g0 = grants;
    repeat (WARMUP + 16) tick();
    check_val("t2_grants", 64'(grants - g0), 64'd4);

    // 3: vector request
    req = 4'b0100; req_vec = 4'b0100;
    repeat (8) tick();

    // 4: reset during the second COLL cycle of a vector
    req = 4'b0010; req_vec = 4'b0010;
    for (int i = 0; i < 20 && !txn_vld; i++) tick();
    check_val("t4_granted", 64'(txn_vld), 64'd1);
    tick();
    Reset = 1; tick();
    Reset = 0; req = 4'b0000;
    tick();
    req = 4'b0010;
    repeat (WARMUP + 8) tick();

    // 5: two requesters held permanently, mixed modes
    req = 4'b0000;
    repeat (6) tick();
    alt_mode = 1; alt_prev = -1; hold_pct = 100;
    req = 4'b1010;
    for (int i = 0; i < 40; i++) begin
      req_vec = NREQ'($urandom);
      tick();
    end
    alt_mode = 0; hold_pct = 0; req = 4'b0000;
    repeat (6) tick();

    // 6: req dropped during COLL still completes
    req = 4'b0001; req_vec = 4'b0000;
    g0 = grants;
    for (int i = 0; i < 10 && !txn_vld; i++) tick();
    req = 4'b0000;
    repeat (8) tick();
    check_val("t6_grants", 64'(grants - g0), 64'd1);

    // Random traffic with occasional resets
    hold_pct = 25;
    for (int i = 0; i < 3000; i++) begin
      for (int r = 0; r < NREQ; r++)
        if (!req[r] && $urandom_range(3) == 0) req[r] = 1'b1;
      req_vec = NREQ'($urandom);
      Reset = ($urandom_range(499) == 0);
      tick();
    end
    Reset = 0;
    check_val("rand_some_grants", 64'(grants > 100), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
